stopwatch_keys: RTL
===================

Name: stopwatch_keys

Overview:
- Button front end that feeds the stopwatch's run/stop and clear/split button inputs.
- Takes raw, bouncing, active-low DE1 KEY inputs and produces clean, synchronised signals per button:
  - a debounced level;
  - one-cycle press and release pulses;
  - a one-shot long-press pulse.
- The stopwatch requires debounced single-cycle button strobes; this block is their producer.

Parameters:
- BN, 2: number of buttons.
- DBP, 1023: debounce period in clk cycles. Input must differ from the debounced level for DBP consecutive cycles before the level changes. Legal range 2 or more.
- DBPL, $clog2(DBP): debounce counter width.
- LPP, 65535: long-press period in clk cycles, counted from the debounced press. Legal range 2 or more.
- LPPL, $clog2(LPP+1): long-press counter width.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- key_n, input, BN: raw buttons, active-low, asynchronous to clk.
- btn, output, BN: debounced level, active-high (1 = pressed).
- b_prs, output, BN: press pulse, one cycle.
- b_rel, output, BN: release pulse, one cycle.
- b_lng, output, BN: long-press pulse, one cycle, at most once per press.

Behaviour:
- Reset (rst=0, async):
  - synchroniser flops set to 1 (released);
  - debounce counters 0; long counters 0; long-done flags 0;
  - btn=0, b_prs=0, b_rel=0, b_lng=0.
- Buttons are fully independent per bit i; no shared state between bits.
- Synchroniser: 2-flop chain per bit. The sampled value s[i] is the inverse of the second flop's output (active-high).
- Debounce, evaluated at each edge:
  - if s[i]==btn[i]: cnt[i]<=0.
  - else if cnt[i]==DBP-1: btn[i]<=s[i], cnt[i]<=0.
  - else: cnt[i]<=cnt[i]+1.
- Latency: if key_n[i] changes and is first captured at edge E and stays stable, btn[i] changes at edge E+1+DBP. Example: DBP=4 gives E+5.
- Glitch rejection: any return of s[i] to btn[i] before the count completes clears cnt[i]. A bounce train therefore delays the transition; it never produces extra transitions.
- Press/release pulses (registered):
  - b_prs[i]=1 for exactly the one cycle following the edge at which btn[i] goes 0->1.
  - b_rel[i]=1 likewise for btn[i] 1->0.
  - Both are 0 otherwise; they are never asserted together.
- Long press:
  - While btn[i]=0: lcnt[i]<=0 and done[i]<=0.
  - While btn[i]=1 and done[i]=0: lcnt[i] increments.
  - At the edge where lcnt[i]==LPP-1: b_lng[i]<=1 for one cycle, done[i]<=1, lcnt[i] holds.
  - Result: b_lng[i] rises at edge R+LPP, where R is the edge at which btn[i] rose.
  - Release before that point produces no b_lng.
  - A held button gives exactly one b_lng; there is no auto-repeat.
- Boundaries:
  - Reset mid-debounce or mid-long-count discards the count. No pulse follows reset release while keys are released.
  - A key held through reset release yields a normal b_prs DBP+2 cycles after reset release.
  - Counters never wrap: cnt[i] is bounded by DBP-1; lcnt[i] is bounded by LPP-1.
- All outputs are registered; there are no combinational paths from key_n to any output.

Test Plan:
- Reset/idle: DBP=4, LPP=16, rst=0 with random key_n
  -> all outputs 0.
  Release rst with key_n=2'b11, run 100 cycles
  -> btn=0, no b_prs, b_rel or b_lng.
- Clean press/release, button 0: key_n[0] 1->0, captured at edge E
  -> btn[0]=1 and b_prs[0]=1 after edge E+5, b_prs for exactly 1 cycle.
  key_n[0] 0->1, captured at edge F
  -> btn[0]=0 and b_rel[0]=1 after edge F+5.
- Bounce: key_n[0] low 3 cycles, high 1, low 2, high 1, then low steady from edge G
  -> no btn change or pulse before edge G+5; single b_prs[0] after edge G+5.
- Long press: hold key_n[1] low; btn[1] rises at edge R
  -> b_lng[1]=1 for one cycle after edge R+16; no further b_lng over 100 more cycles.
  Repeat with release 10 cycles after R
  -> no b_lng[1]; b_rel[1] occurs.
- Simultaneous and independent: both keys pressed in the same cycle
  -> b_prs=2'b11 in the same cycle.
  Button 1 bounces while button 0 is steady
  -> button 0 unaffected.
- Reset mid-operation: assert rst 2 cycles before a debounce would complete, then release with the key still pressed
  -> no pulse from the old count; btn[i] and b_prs[i] occur exactly DBP+2 cycles after reset release.

Source files
------------

// File: rtl/stopwatch_keys.sv
// Button front end: synchronises raw active-low keys, debounces them, and emits
// one-cycle press, release and one-shot long-press strobes per button.
module stopwatch_keys #(
  parameter int BN   = 2,
  parameter int DBP  = 1023,
  parameter int DBPL = $clog2(DBP),
  parameter int LPP  = 65535,
  parameter int LPPL = $clog2(LPP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BN-1:0] key_n,
  output logic [BN-1:0] btn,
  output logic [BN-1:0] b_prs,
  output logic [BN-1:0] b_rel,
  output logic [BN-1:0] b_lng
);

  logic [BN-1:0] sync1;
  logic [BN-1:0] sync2;
  logic [BN-1:0] s;

  // Synchroniser resets to "released" so reset release alone never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar i = 0; i < BN; i++) begin : g_btn
    logic [DBPL-1:0] cnt;
    logic [LPPL-1:0] lcnt;
    logic            done;
    logic            lvl;
    logic            prs;
    logic            rel;
    logic            lng;

    // Any sample agreeing with the current level restarts the count, so bounces only delay.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        if (s[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == DBPL'(DBP - 1)) begin
          lvl <= s[i];
          cnt <= '0;
          prs <= s[i];
          rel <= ~s[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Long-press timer; done holds it off until the button is released.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lcnt <= '0;
        done <= 1'b0;
        lng  <= 1'b0;
      end else begin
        lng <= 1'b0;
        if (!lvl) begin
          lcnt <= '0;
          done <= 1'b0;
        end else if (!done) begin
          if (lcnt == LPPL'(LPP - 1)) begin
            lng  <= 1'b1;
            done <= 1'b1;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
      end
    end

    assign btn[i]   = lvl;
    assign b_prs[i] = prs;
    assign b_rel[i] = rel;
    assign b_lng[i] = lng;
  end

endmodule
